serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor that computes A - B, LSB first, one bit per clock, using a single 1-bit full-adder cell and a carry flip-flop. It is the subtract-direction companion to the combinational full-adder block. It serves as the sequential datapath exercise in the basic Verilog drills, with a start/done handshake toward a controller or testbench.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/fulladder.sv | 13 +
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; a 1-bit floor keeps tiny operand widths legal.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder cell shared by the arithmetic drills.
module fulladder (
  output logic o_w_s,
  output logic o_w_cout,
  input  logic i_w_a,
  input  logic i_w_b,
  input  logic i_w_cin
);

  assign o_w_s    = i_w_a ^ i_w_b ^ i_w_cin;
  assign o_w_cout = (i_w_a & i_w_b) | (i_w_cin & (i_w_a ^ i_w_b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, computed as A + ~B + 1 through one full-adder cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_w_clk,
  input  logic             i_w_rst_n,
  input  logic             i_w_start,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  output logic             o_w_busy,
  output logic             o_w_done,
  output logic [WIDTH-1:0] o_w_diff,
  output logic             o_w_borrow,
  output logic             o_w_zero,
  output logic             o_w_overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] nb_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] next_res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic             sum;
  logic             cout;
  logic             accept;

  fulladder u_fa (
    .o_w_s    (sum),
    .o_w_cout (cout),
    .i_w_a    (a_sr[0]),
    .i_w_b    (nb_sr[0]),
    .i_w_cin  (carry)
  );

  assign next_res = {sum, res_sr[WIDTH-1:1]};
  assign accept   = i_w_start && (state == IDLE || state == DONE);
  assign o_w_busy = (state == RUN);

  always_ff @(posedge i_w_clk) begin
    if (!i_w_rst_n) begin
      state        <= IDLE;
      a_sr         <= '0;
      nb_sr        <= '0;
      res_sr       <= '0;
      cnt          <= '0;
      carry        <= 1'b0;
      a_msb        <= 1'b0;
      b_msb        <= 1'b0;
      o_w_done     <= 1'b0;
      o_w_diff     <= '0;
      o_w_borrow   <= 1'b0;
      o_w_zero     <= 1'b0;
      o_w_overflow <= 1'b0;
    end else begin
      o_w_done <= 1'b0;
      if (accept) begin
        // Inverted B plus a carry-in of 1 forms the two's-complement negation.
        a_sr  <= i_w_a;
        nb_sr <= ~i_w_b;
        carry <= 1'b1;
        cnt   <= '0;
        a_msb <= i_w_a[WIDTH-1];
        b_msb <= i_w_b[WIDTH-1];
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            res_sr <= next_res;
            carry  <= cout;
            a_sr   <= a_sr >> 1;
            nb_sr  <= nb_sr >> 1;
            if (cnt == LAST) begin
              o_w_diff     <= next_res;
              o_w_borrow   <= ~cout;
              o_w_zero     <= (next_res == '0);
              o_w_overflow <= (a_msb != b_msb) && (next_res[WIDTH-1] != a_msb);
              o_w_done     <= 1'b1;
              state        <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor at WIDTH=8 and an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

  logic       clk;
  logic       rst8, start8, busy8, done8, borrow8, zero8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       rst4, start4, busy4, done4, borrow4, zero4, ovf4;
  logic [3:0] a4, b4, diff4;

  int checks = 0;
  int passes = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .i_w_clk(clk), .i_w_rst_n(rst8), .i_w_start(start8), .i_w_a(a8), .i_w_b(b8),
    .o_w_busy(busy8), .o_w_done(done8), .o_w_diff(diff8), .o_w_borrow(borrow8),
    .o_w_zero(zero8), .o_w_overflow(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .i_w_clk(clk), .i_w_rst_n(rst4), .i_w_start(start4), .i_w_a(a4), .i_w_b(b4),
    .o_w_busy(busy4), .o_w_done(done4), .o_w_diff(diff4), .o_w_borrow(borrow4),
    .o_w_zero(zero4), .o_w_overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [35:0] model(input int w, input int a, input int b);
    int m, d, sa, sb, sd;
    logic br, z, ov;
    m  = 1 << w;
    d  = ((a - b) % m + m) % m;
    br = (a < b);
    z  = (d == 0);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sd = sa - sb;
    ov = (sd < -(m / 2)) || (sd >= m / 2);
    return {d[31:0], br, z, ov, 1'b0};
  endfunction

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, output int lat, output int busy_n);
    bit ok;
    a8 = a; b8 = b; start8 = 1'b1;
    lat = 0; busy_n = 0; ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (busy8) busy_n++;
      if (done8) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) $display("[TB] FAIL op8_timeout a=%h b=%h: no done within 40 cycles", a, b);
    else passes++;
  endtask

  task automatic check_result8(input string name, input logic [7:0] a, input logic [7:0] b);
    logic [35:0] e;
    e = model(8, int'(a), int'(b));
    checks++;
    if ({diff8, borrow8, zero8, ovf8} !== {e[11:4], e[3], e[2], e[1]})
      $display("[TB] FAIL %s a=%h b=%h got diff=%h br=%b z=%b ov=%b expected diff=%h br=%b z=%b ov=%b",
               name, a, b, diff8, borrow8, zero8, ovf8, e[11:4], e[3], e[2], e[1]);
    else passes++;
  endtask

  task automatic test_reset;
    rst8 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, diff8, borrow8, zero8, ovf8} !== 13'd0)
      $display("[TB] FAIL reset_state got %b expected 0", {busy8, done8, diff8, borrow8, zero8, ovf8});
    else passes++;
    rst8 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [7:0] ta [5] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h42};
    logic [7:0] tb [5] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h42};
    logic [7:0] held;
    int lat, busy_n;
    for (int i = 0; i < 5; i++) begin
      do_op8(ta[i], tb[i], lat, busy_n);
      check_result8("directed", ta[i], tb[i]);
      held = diff8;
      checks++;
      if (lat != 9 || busy_n != 8)
        $display("[TB] FAIL latency got lat=%0d busy=%0d expected lat=9 busy=8", lat, busy_n);
      else passes++;
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== held)
        $display("[TB] FAIL done_pulse got done=%b busy=%b diff=%h expected done=0 busy=0 diff=%h",
                 done8, busy8, diff8, held);
      else passes++;
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit ok, held_ok;
    a8 = 8'h42; b8 = 8'h42; start8 = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h01;
      if (done8) begin ok = 1; break; end
    end
    checks++;
    if (!ok || diff8 !== 8'h00 || zero8 !== 1'b1 || borrow8 !== 1'b0)
      $display("[TB] FAIL start_held got done=%b diff=%h z=%b br=%b expected 1/00/1/0", ok, diff8, zero8, borrow8);
    else passes++;
    // Start still high in DONE: the next op begins immediately with 0x10/0x01.
    ok = 0; n = 0; held_ok = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) start8 = 1'b0;
      if (done8) begin ok = 1; break; end
      if (diff8 !== 8'h00 || busy8 !== 1'b1) held_ok = 0;
    end
    checks++;
    if (!ok || n != 9 || diff8 !== 8'h0F || !held_ok)
      $display("[TB] FAIL back_to_back got done=%b lat=%0d diff=%h hold=%b expected 1/9/0f/1", ok, n, diff8, held_ok);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int done_n, lat, busy_n;
    a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy8, done8, diff8, borrow8, zero8, ovf8} !== 13'd0)
      $display("[TB] FAIL reset_mid_run got %b expected 0", {busy8, done8, diff8, borrow8, zero8, ovf8});
    else passes++;
    rst8 = 1'b1;
    done_n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) done_n++;
    end
    checks++;
    if (done_n != 0) $display("[TB] FAIL abort_quiet got %0d active cycles expected 0", done_n);
    else passes++;
    do_op8(8'h05, 8'h03, lat, busy_n);
    check_result8("restart", 8'h05, 8'h03);
    @(negedge clk);
  endtask

  task automatic test_random8;
    logic [7:0] a, b;
    int lat, busy_n;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 6 == 0) b = a;
      do_op8(a, b, lat, busy_n);
      check_result8("random8", a, b);
      if (i % 2 == 0) @(negedge clk);
    end
  endtask

  task automatic test_sweep4;
    logic [35:0] e;
    logic [3:0]  prev;
    bit ok, stable;
    rst4 = 1'b0; start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    prev = diff4;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        a4 = 4'(a); b4 = 4'(b); start4 = 1'b1;
        ok = 0; stable = 1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          start4 = 1'b0;
          a4 = 4'($urandom);
          if (done4) begin ok = 1; break; end
          if (diff4 !== prev) stable = 0;
        end
        e = model(4, a, b);
        checks++;
        if (!ok || {diff4, borrow4, zero4, ovf4} !== {e[7:4], e[3], e[2], e[1]})
          $display("[TB] FAIL sweep4 a=%h b=%h got done=%b diff=%h br=%b z=%b ov=%b expected diff=%h br=%b z=%b ov=%b",
                   4'(a), 4'(b), ok, diff4, borrow4, zero4, ovf4, e[7:4], e[3], e[2], e[1]);
        else passes++;
        checks++;
        if (!stable) $display("[TB] FAIL hold4 a=%h b=%h: diff left %h before done", 4'(a), 4'(b), prev);
        else passes++;
        prev = diff4;
      end
    end
  endtask

  initial begin
    rst4 = 1'b0; start4 = 1'b0; a4 = '0; b4 = '0;
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_mid_run;
    test_random8;
    test_sweep4;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
